// File: rtl/responder_pkg.sv
// Shared state and result encodings for the quiz responder arbiter.
package responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ANSWER = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_OK      = 2'd1,
        RES_WRONG   = 2'd2,
        RES_TIMEOUT = 2'd3
    } result_t;

    localparam int TIME_W = 8;

endpackage

// File: rtl/responder_countdown.sv
// Per-second down-counter shared by the buzzing window and the answer window.
module responder_countdown
    import responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              tick,
    output logic [TIME_W-1:0] time_left,
    output logic              expire
);

    always_ff @(posedge clk) begin
        if (rst) begin
            time_left <= '0;
        end else if (load) begin
            time_left <= load_val;
        end else if (run && tick && time_left != '0) begin
            time_left <= time_left - 1'b1;
        end
    end

    assign expire = tick && (time_left == TIME_W'(1));

endmodule

// File: rtl/responder_arbiter.sv
// First-press arbiter and round sequencer: locks the first buzzer, times the
// answer, scores the verdict and flags false starts.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no round; presses mark fouls
// ST_ARMED  | round open, first unfouled press wins; ARM_SECS window
// ST_ANSWER | winner locked, awaiting verdict; ANS_SECS window
// ST_DONE   | round over, winner/result/time held; presses mark fouls
module responder_arbiter
    import responder_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int ARM_SECS  = 10,
    parameter int ANS_SECS  = 20,
    parameter int SCORE_W   = 4,
    parameter int SCORE_MAX = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic                          start_round,
    input  logic [N_PLAYERS-1:0]          buzz,
    input  logic                          yes,
    input  logic                          no,
    input  logic                          clear_scores,
    output logic                          show_ready,
    output logic                          show_time,
    output logic                          show_who,
    output logic [$clog2(N_PLAYERS)-1:0]  winner_id,
    output logic [TIME_W-1:0]             time_left,
    output logic [1:0]                    result,
    output logic [N_PLAYERS-1:0]          foul,
    output logic [N_PLAYERS*SCORE_W-1:0]  scores
);

    localparam int ID_W = $clog2(N_PLAYERS);

    state_t               state, state_n;
    result_t              result_q, result_n;
    logic [ID_W-1:0]      win_enc, winner_n;
    logic [N_PLAYERS-1:0] buzz_q, press, cand, foul_n;
    logic                 who_n, cd_load, cd_run, expire;
    logic [TIME_W-1:0]    cd_val;
    logic                 score_inc, score_dec, v_yes, v_no;
    logic [SCORE_W-1:0]   score_q [N_PLAYERS];

    assign press  = buzz & ~buzz_q;
    assign cand   = press & ~foul;
    assign v_yes  = yes && !no;
    assign v_no   = no && !yes;
    assign cd_run = (state == ST_ARMED) || (state == ST_ANSWER);
    assign result = result_q;

    // Lowest index wins a simultaneous press.
    always_comb begin
        win_enc = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (cand[i]) win_enc = ID_W'(i);
        end
    end

    always_comb begin
        state_n   = state;
        result_n  = result_q;
        winner_n  = winner_id;
        foul_n    = foul;
        who_n     = show_who;
        cd_load   = 1'b0;
        cd_val    = '0;
        score_inc = 1'b0;
        score_dec = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                foul_n = foul | press;
                if (start_round) begin
                    state_n  = ST_ARMED;
                    result_n = RES_NONE;
                    who_n    = 1'b0;
                    cd_load  = 1'b1;
                    cd_val   = TIME_W'(ARM_SECS);
                end
            end
            ST_ARMED: begin
                if (|cand) begin
                    state_n  = ST_ANSWER;
                    winner_n = win_enc;
                    who_n    = 1'b1;
                    cd_load  = 1'b1;
                    cd_val   = TIME_W'(ANS_SECS);
                end else if (expire) begin
                    state_n  = ST_DONE;
                    result_n = RES_NONE;
                    foul_n   = '0;
                end
            end
            ST_ANSWER: begin
                if (v_yes) begin
                    state_n   = ST_DONE;
                    result_n  = RES_OK;
                    score_inc = 1'b1;
                    foul_n    = '0;
                end else if (v_no) begin
                    state_n   = ST_DONE;
                    result_n  = RES_WRONG;
                    score_dec = 1'b1;
                    foul_n    = '0;
                end else if (expire) begin
                    state_n  = ST_DONE;
                    result_n = RES_TIMEOUT;
                    foul_n   = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (clear_scores) begin
            state_n   = ST_IDLE;
            result_n  = RES_NONE;
            foul_n    = '0;
            who_n     = 1'b0;
            score_inc = 1'b0;
            score_dec = 1'b0;
            cd_load   = 1'b1;
            cd_val    = '0;
        end
    end

    // Display flags are registered from the next state so they never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            result_q   <= RES_NONE;
            winner_id  <= '0;
            foul       <= '0;
            buzz_q     <= '0;
            show_ready <= 1'b0;
            show_time  <= 1'b0;
            show_who   <= 1'b0;
        end else begin
            state      <= state_n;
            result_q   <= result_n;
            winner_id  <= winner_n;
            foul       <= foul_n;
            buzz_q     <= buzz;
            show_ready <= (state_n == ST_ARMED);
            show_time  <= (state_n == ST_ANSWER);
            show_who   <= who_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_scores) begin
            for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
        end else if (score_inc && score_q[winner_id] < SCORE_W'(SCORE_MAX)) begin
            score_q[winner_id] <= score_q[winner_id] + 1'b1;
        end else if (score_dec && score_q[winner_id] != '0) begin
            score_q[winner_id] <= score_q[winner_id] - 1'b1;
        end
    end

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_pack
        assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    responder_countdown u_countdown (
        .clk       (clk),
        .rst       (rst),
        .run       (cd_run),
        .load      (cd_load),
        .load_val  (cd_val),
        .tick      (tick),
        .time_left (time_left),
        .expire    (expire)
    );

endmodule

// File: tb/tb_responder_arbiter.sv
// Scoreboard bench for responder_arbiter: directed rounds push expected
// outputs tagged with the cycle they must appear; a monitor pops and compares.
module tb_responder_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0, start_round = 1'b0, yes = 1'b0, no = 1'b0, clear_scores = 1'b0;
    logic [3:0]  buzz = 4'b0;
    logic        show_ready, show_time, show_who;
    logic [1:0]  winner_id;
    logic [7:0]  time_left;
    logic [1:0]  result;
    logic [3:0]  foul;
    logic [15:0] scores;

    responder_arbiter #(
        .N_PLAYERS(4), .ARM_SECS(10), .ANS_SECS(20), .SCORE_W(4), .SCORE_MAX(9)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start_round(start_round), .buzz(buzz),
        .yes(yes), .no(no), .clear_scores(clear_scores),
        .show_ready(show_ready), .show_time(show_time), .show_who(show_who),
        .winner_id(winner_id), .time_left(time_left), .result(result),
        .foul(foul), .scores(scores)
    );

    always #5 clk = ~clk;

    typedef enum {K_SHOW, K_WHO, K_WIN, K_TIME, K_RES, K_FOUL, K_SCORES} kind_t;
    typedef struct {
        string       name;
        kind_t       kind;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input kind_t k);
        case (k)
            K_SHOW:   return {30'd0, show_ready, show_time};
            K_WHO:    return {31'd0, show_who};
            K_WIN:    return {30'd0, winner_id};
            K_TIME:   return {24'd0, time_left};
            K_RES:    return {30'd0, result};
            K_FOUL:   return {28'd0, foul};
            default:  return {16'd0, scores};
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    failures++;
                    $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end else if (actual(e.kind) !== e.val) begin
                    failures++;
                    $display("FAIL %s: got %0h required %0h (cycle %0d)", e.name, actual(e.kind), e.val, cyc);
                end
            end
        end
    end

    task automatic drive(input logic st, input logic tk, input logic y, input logic n,
                         input logic c, input logic [3:0] b);
        @(negedge clk);
        start_round = st; tick = tk; yes = y; no = n; clear_scores = c; buzz = b;
    endtask

    task automatic exp_next(input string nm, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.name = nm; e.kind = k; e.val = v; e.cyc = cyc + 1;
        sbq.push_back(e);
    endtask

    initial begin : watchdog
        #200000;
        if (!done) begin
            failures++;
            $display("FAIL watchdog: got timeout required stimulus completion");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin : stimulus
        // reset state
        drive(0, 0, 0, 0, 0, 4'b0000);
        exp_next("rst_show", K_SHOW, 0);
        exp_next("rst_who", K_WHO, 0);
        exp_next("rst_time", K_TIME, 0);
        exp_next("rst_res", K_RES, 0);
        exp_next("rst_foul", K_FOUL, 0);
        exp_next("rst_scores", K_SCORES, 0);

        // false start in IDLE, masked in ARMED, cleared on DONE
        drive(0, 0, 0, 0, 0, 4'b0001); rst = 1'b0;
        exp_next("fs_foul_set", K_FOUL, 4'b0001);
        exp_next("fs_idle_show", K_SHOW, 0);
        drive(0, 0, 0, 0, 0, 4'b0000);
        drive(1, 0, 0, 0, 0, 4'b0000);
        exp_next("fs_armed", K_SHOW, 2'b10);
        exp_next("fs_foul_kept", K_FOUL, 4'b0001);
        drive(0, 0, 0, 0, 0, 4'b0001);
        exp_next("fs_masked_press", K_SHOW, 2'b10);
        drive(0, 0, 0, 0, 0, 4'b0011);
        exp_next("fs_win", K_WIN, 1);
        exp_next("fs_ans_show", K_SHOW, 2'b01);
        exp_next("fs_ans_time", K_TIME, 20);
        drive(0, 0, 1, 0, 0, 4'b0011);
        exp_next("fs_res", K_RES, 1);
        exp_next("fs_foul_clr", K_FOUL, 0);
        exp_next("fs_scores", K_SCORES, 16'h0010);
        drive(0, 0, 0, 0, 0, 4'b0000);

        // basic win for contestant 2
        drive(1, 0, 0, 0, 0, 4'b0000);
        exp_next("bw_armed", K_SHOW, 2'b10);
        exp_next("bw_arm_time", K_TIME, 10);
        exp_next("bw_res_clr", K_RES, 0);
        exp_next("bw_who_low", K_WHO, 0);
        drive(0, 0, 0, 0, 0, 4'b0100);
        exp_next("bw_show", K_SHOW, 2'b01);
        exp_next("bw_who", K_WHO, 1);
        exp_next("bw_win", K_WIN, 2);
        exp_next("bw_time", K_TIME, 20);
        drive(0, 1, 0, 0, 0, 4'b0100);
        exp_next("bw_tick", K_TIME, 19);
        drive(0, 0, 1, 0, 0, 4'b0100);
        exp_next("bw_res", K_RES, 1);
        exp_next("bw_scores", K_SCORES, 16'h0110);
        exp_next("bw_done_show", K_SHOW, 0);
        exp_next("bw_done_who", K_WHO, 1);
        drive(0, 0, 0, 0, 0, 4'b0000);
        exp_next("bw_release_nofoul", K_FOUL, 0);

        // tie resolves to lowest index; later edges ignored; wrong answer
        drive(1, 0, 0, 0, 0, 4'b0000);
        drive(0, 0, 0, 0, 0, 4'b1010);
        exp_next("tie_win", K_WIN, 1);
        drive(0, 0, 0, 0, 0, 4'b1011);
        exp_next("tie_late_win", K_WIN, 1);
        exp_next("tie_late_show", K_SHOW, 2'b01);
        drive(0, 0, 0, 1, 0, 4'b1011);
        exp_next("tie_res", K_RES, 2);
        exp_next("tie_dec", K_SCORES, 16'h0100);
        drive(1, 0, 0, 0, 0, 4'b0000);
        drive(0, 0, 0, 0, 0, 4'b0010);
        exp_next("zero_win", K_WIN, 1);
        drive(0, 0, 0, 1, 0, 4'b0010);
        exp_next("zero_res", K_RES, 2);
        exp_next("zero_floor", K_SCORES, 16'h0100);

        // yes&no ignored, then answer timeout
        drive(1, 0, 0, 0, 0, 4'b0000);
        drive(0, 0, 0, 0, 0, 4'b1000);
        exp_next("yn_win", K_WIN, 3);
        drive(0, 0, 1, 1, 0, 4'b1000);
        exp_next("yn_show", K_SHOW, 2'b01);
        exp_next("yn_res", K_RES, 0);
        exp_next("yn_scores", K_SCORES, 16'h0100);
        exp_next("yn_time", K_TIME, 20);
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 0, 0, 0, 4'b1000);
            exp_next("ans_countdown", K_TIME, 20 - i);
            if (i == 20) begin
                exp_next("ans_to_res", K_RES, 3);
                exp_next("ans_to_show", K_SHOW, 0);
                exp_next("ans_to_scores", K_SCORES, 16'h0100);
            end
        end
        drive(0, 1, 0, 0, 0, 4'b1000);
        exp_next("done_no_wrap", K_TIME, 0);
        exp_next("done_res_hold", K_RES, 3);

        // saturation at 9 for contestant 3
        for (int i = 1; i <= 10; i++) begin
            drive(1, 0, 0, 0, 0, 4'b0000);
            drive(0, 0, 0, 0, 0, 4'b1000);
            drive(0, 0, 1, 0, 0, 4'b1000);
            exp_next("sat_res", K_RES, 1);
            exp_next("sat_score", K_SCORES, {(i > 9) ? 4'd9 : 4'(i), 12'h100});
        end

        // buzzing window expires with no press
        drive(1, 0, 0, 0, 0, 4'b0000);
        exp_next("arm_to_load", K_TIME, 10);
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, 0, 0, 0, 4'b0000);
            exp_next("arm_countdown", K_TIME, 10 - i);
            if (i == 10) begin
                exp_next("arm_to_show", K_SHOW, 0);
                exp_next("arm_to_res", K_RES, 0);
            end
        end

        // clear_scores mid-ANSWER
        drive(1, 0, 0, 0, 0, 4'b0000);
        drive(0, 0, 0, 0, 0, 4'b0100);
        exp_next("clr_pre_win", K_WIN, 2);
        drive(0, 0, 0, 0, 1, 4'b0100);
        exp_next("clr_show", K_SHOW, 0);
        exp_next("clr_who", K_WHO, 0);
        exp_next("clr_scores", K_SCORES, 0);
        exp_next("clr_res", K_RES, 0);
        drive(1, 0, 0, 0, 0, 4'b0100);
        exp_next("clr_rearm", K_SHOW, 2'b10);

        // reset mid-ARMED, button held through reset
        drive(0, 1, 0, 0, 0, 4'b0100);
        exp_next("rm_tick", K_TIME, 9);
        drive(0, 0, 0, 0, 0, 4'b0100); rst = 1'b1;
        exp_next("rm_show", K_SHOW, 0);
        exp_next("rm_who", K_WHO, 0);
        exp_next("rm_win", K_WIN, 0);
        exp_next("rm_time", K_TIME, 0);
        exp_next("rm_res", K_RES, 0);
        exp_next("rm_foul", K_FOUL, 0);
        drive(0, 0, 0, 0, 0, 4'b0100); rst = 1'b0;
        exp_next("rm_held_press_foul", K_FOUL, 4'b0100);
        exp_next("rm_idle_show", K_SHOW, 0);

        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sbq.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/responder_arbiter.md
# responder_arbiter

First-press arbiter and round sequencer for the quiz responder. Arms a round on host command, locks onto the first contestant to buzz, runs the per-second answer countdown, applies the judge's verdict to a per-contestant score register, and flags early (false-start) presses. Sits between the debounced contestant buttons and host keys on one side and the display/score-render logic on the other.

## Interface
- `N_PLAYERS`, 4: number of contestants, 2..8.
- `ARM_SECS`, 10: seconds the round stays open for buzzing.
- `ANS_SECS`, 20: seconds allowed to answer after lock.
- `SCORE_W`, 4: score width per contestant.
- `SCORE_MAX`, 9: saturation ceiling, must be ≤ 2^SCORE_W−1.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous and active-high.
- `tick` in 1: one-cycle strobe, once per second.
- `start_round` in 1: host pulse, arm a round.
- `buzz` in N_PLAYERS: contestant buttons, already synchronized and debounced, level.
- `yes` in 1: judge verdict, correct (pulse).
- `no` in 1: judge verdict, wrong (pulse).
- `clear_scores` in 1: zero all scores, abort round.
- `show_ready` out 1: high in ARMED.
- `show_time` out 1: high in ANSWER.
- `show_who` out 1: winner_id valid (ANSWER, DONE).
- `winner_id` out clog2(N_PLAYERS): locked contestant.
- `time_left` out 8: remaining seconds of the active countdown.
- `result` out 2: 0 none, 1 correct, 2 wrong, 3 timeout; valid in DONE.
- `foul` out N_PLAYERS: false-start mask.
- `scores` out N_PLAYERS*SCORE_W: packed, contestant i at [i*SCORE_W +: SCORE_W].

## Operation
- **States:** IDLE, ARMED, ANSWER, DONE.
- **Edge detection:** internal registered copy of `buzz`; a press is a rising edge only. Holding a button never re-triggers.
- **IDLE/DONE → ARMED** on `start_round`:
  - load `time_left` = ARM_SECS;
  - `result` ← 0;
  - `show_who` low.
- **Fouls:**
  - A press in IDLE or DONE sets the corresponding `foul` bit.
  - In ARMED, presses from fouled contestants are ignored.
  - `foul` clears on entry to DONE (the round it penalized has ended).
- **ARMED → ANSWER** on any unmasked press:
  - `winner_id` = lowest-index pressing contestant (simultaneous presses → lowest index wins);
  - load `time_left` = ANS_SECS.
- **ARMED → DONE** with `result`=0 when `tick` arrives with `time_left`==1; `time_left` → 0.
- **ANSWER:**
  - `tick` decrements `time_left`.
  - `yes` → DONE, `result`=1, score[winner] +1 saturating at SCORE_MAX.
  - `no` → DONE, `result`=2, score[winner] −1 saturating at 0.
  - `tick` with `time_left`==1 → DONE, `result`=3, score unchanged.
- **Simultaneous events:**
  - `yes`&`no` together → both ignored.
  - Verdict and timeout tick in the same cycle → verdict wins.
  - `yes`/`no` outside ANSWER → no effect.
  - `start_round` in ARMED/ANSWER → ignored.
- **DONE:** holds `winner_id`, `result`, and `time_left` until `start_round`.
- **`clear_scores`** (any state, priority over everything except `rst`):
  - all scores 0;
  - `foul` 0;
  - → IDLE;
  - `result` 0.

## Timing
- **Reset:**
  - state IDLE;
  - all outputs 0;
  - scores 0;
  - edge-detect register loaded with 0, so a button held through reset produces one press after release of `rst`.
- **Press latency:** press edge visible on `buzz` at cycle k → state ANSWER, `show_who`=1, `winner_id` valid at k+1.
- **Verdict latency:** verdict at cycle k → `result` and updated `scores` at k+1.
- **Countdown:** `time_left` changes only on `tick` cycles (plus loads); never wraps below 0.
- **State-decoded outputs:** `show_ready` and `show_time` are registered, state-decoded, with no glitches.

## Structure
- **Package `responder_pkg`:**
  - state enum;
  - result codes (RES_NONE, RES_OK, RES_WRONG, RES_TIMEOUT).
- **Sub-module `responder_countdown`:**
  - inputs: load, load value, tick;
  - outputs: `time_left`, `expire` (combinational tick & `time_left`==1);
  - instantiated once and shared by ARMED and ANSWER.
- Priority encoder and score array stay in the top module.

## Test plan
- **Basic win:** `start_round`, `buzz`=0100 → next cycle ANSWER, `winner_id`=2, `time_left`=20; `yes` → `result`=1, score2=1.
- **Tie:** `buzz`=1010 in the same cycle → `winner_id`=1; later `buzz` edges ignored in ANSWER.
- **False start:** `buzz[0]` pressed in IDLE → `foul`=0001; `start_round`, `buzz`=0001 → still ARMED. Then `buzz`=0010 → winner 1; `foul` clears on DONE.
- **Timeouts:**
  - ANS_SECS ticks with no verdict → DONE, `result`=3, `time_left`=0, scores unchanged.
  - ARM_SECS ticks with no press → DONE, `result`=0.
- **Saturation:**
  - 10× correct for contestant 3 → score3 stays 9.
  - `no` for a contestant at 0 → stays 0.
  - `yes`&`no` together → state unchanged.
- **Abort/reset:**
  - `clear_scores` mid-ANSWER → IDLE, scores 0, `show_who`=0.
  - `rst` asserted mid-ARMED → all outputs 0 at the next edge.
